// File: rtl/smg_bcd_convert_module.sv
// Binary-to-BCD converter for a six-digit display, using 20-iteration double-dabble; Done_Sig 21 cycles after load (1 cycle on overflow).
// Build with SMG_LEADING_ZERO_BLANK_EN defined to replace leading zero digits with blank code 4'hF.
module smg_bcd_convert_module (
  input  logic        CLK,
  input  logic        RST,
  input  logic [19:0] Bin_Data,
  input  logic        Load_Sig,
  output logic [23:0] Number_Sig,
  output logic        Busy_Sig,
  output logic        Done_Sig,
  output logic        Ovf_Sig
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [19:0] MAX_VALUE  = 20'd999999;
  localparam logic [4:0]  LAST_ITER  = 5'd19;
  localparam logic [23:0] SATURATED  = 24'h999999;

  state_t      state;
  logic [4:0]  iter_cnt;
  logic [19:0] bin_sr;
  logic [23:0] bcd_sr;
  logic [23:0] bcd_adj;
  logic [23:0] bcd_next;

  function automatic logic [23:0] fmt_digits(input logic [23:0] d);
    logic [23:0] r;
`ifdef SMG_LEADING_ZERO_BLANK_EN
    logic leading;
    r       = d;
    leading = 1'b1;
    // The least significant digit is excluded so a zero value still shows "0".
    for (int i = 5; i >= 1; i--) begin
      if (leading && (d[i*4 +: 4] == 4'd0)) begin
        r[i*4 +: 4] = 4'hF;
      end else begin
        leading = 1'b0;
      end
    end
`else
    r = d;
`endif
    return r;
  endfunction

  // One double-dabble step: correct every nibble >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 6; i++) begin
      if (bcd_sr[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
      end
    end
    bcd_next = {bcd_adj[22:0], bin_sr[19]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      iter_cnt   <= 5'd0;
      bin_sr     <= 20'd0;
      bcd_sr     <= 24'd0;
      Number_Sig <= 24'h000000;
      Busy_Sig   <= 1'b0;
      Done_Sig   <= 1'b0;
      Ovf_Sig    <= 1'b0;
    end else begin
      Done_Sig <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (Load_Sig) begin
            iter_cnt <= 5'd0;
            if (Bin_Data > MAX_VALUE) begin
              state      <= DONE;
              Number_Sig <= fmt_digits(SATURATED);
              Ovf_Sig    <= 1'b1;
              Done_Sig   <= 1'b1;
              Busy_Sig   <= 1'b0;
            end else begin
              state    <= CONV;
              bin_sr   <= Bin_Data;
              bcd_sr   <= 24'd0;
              Busy_Sig <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        CONV: begin
          // Load_Sig is deliberately not looked at here.
          bin_sr   <= {bin_sr[18:0], 1'b0};
          bcd_sr   <= bcd_next;
          iter_cnt <= iter_cnt + 5'd1;
          if (iter_cnt == LAST_ITER) begin
            state      <= DONE;
            Number_Sig <= fmt_digits(bcd_next);
            Busy_Sig   <= 1'b0;
            Done_Sig   <= 1'b1;
            Ovf_Sig    <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          Busy_Sig <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smg_bcd_convert_module.sv
// Directed bench for smg_bcd_convert_module: conversion latency, overflow, ignored loads, reset abort.
module tb_smg_bcd_convert_module;

  logic        CLK;
  logic        RST;
  logic [19:0] Bin_Data;
  logic        Load_Sig;
  logic [23:0] Number_Sig;
  logic        Busy_Sig;
  logic        Done_Sig;
  logic        Ovf_Sig;

  int n_checks;
  int n_pass;
  logic [23:0] exp_num;

  smg_bcd_convert_module dut (
    .CLK        (CLK),
    .RST        (RST),
    .Bin_Data   (Bin_Data),
    .Load_Sig   (Load_Sig),
    .Number_Sig (Number_Sig),
    .Busy_Sig   (Busy_Sig),
    .Done_Sig   (Done_Sig),
    .Ovf_Sig    (Ovf_Sig)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [23:0] sel(input logic [23:0] plain, input logic [23:0] blanked);
`ifdef SMG_LEADING_ZERO_BLANK_EN
    return blanked;
`else
    return plain;
`endif
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  // Called #1 after an edge; returns #1 after the edge that starts cycle 21 (DONE).
  task automatic run_conv(input string tag, input logic [19:0] val, input logic [23:0] exp,
                          input int inj_cycle, input logic [19:0] inj_val, input logic ovf_during);
    int busy_cnt, hold_err, done_err, ovf_err;
    busy_cnt = 0; hold_err = 0; done_err = 0; ovf_err = 0;
    Bin_Data = val;
    Load_Sig = 1'b1;
    @(posedge CLK); #1;
    Load_Sig = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (Busy_Sig === 1'b1) busy_cnt++;
      if (Number_Sig !== exp_num) hold_err++;
      if (Done_Sig !== 1'b0) done_err++;
      if (Ovf_Sig !== ovf_during) ovf_err++;
      if (c == inj_cycle) begin
        Bin_Data = inj_val;
        Load_Sig = 1'b1;
      end else begin
        Load_Sig = 1'b0;
      end
      @(posedge CLK); #1;
    end
    Load_Sig = 1'b0;
    check({tag, "_busy_cycles"}, busy_cnt, 20);
    check({tag, "_hold"}, hold_err, 0);
    check({tag, "_no_early_done"}, done_err, 0);
    check({tag, "_ovf_during"}, ovf_err, 0);
    check({tag, "_done"}, Done_Sig, 1);
    check({tag, "_busy_off"}, Busy_Sig, 0);
    check({tag, "_number"}, Number_Sig, exp);
    check({tag, "_ovf"}, Ovf_Sig, 0);
    exp_num = exp;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_num  = 24'h000000;
    RST      = 1'b1;
    Load_Sig = 1'b0;
    Bin_Data = 20'd0;

    // Reset state, with a load request that must be ignored while reset is held.
    #3;
    check("rst_number", Number_Sig, 24'h000000);
    check("rst_busy", Busy_Sig, 0);
    check("rst_done", Done_Sig, 0);
    check("rst_ovf", Ovf_Sig, 0);
    Bin_Data = 20'd123;
    Load_Sig = 1'b1;
    @(posedge CLK); #1;
    check("rst_load_ignored", Busy_Sig, 0);
    Load_Sig = 1'b0;
    RST = 1'b0;
    idle_cycles(2);

    run_conv("v123456", 20'd123456, 24'h123456, 0, 20'd0, 1'b0);
    @(posedge CLK); #1;
    check("v123456_done_pulse_end", Done_Sig, 0);
    check("v123456_number_kept", Number_Sig, 24'h123456);
    idle_cycles(1);

    run_conv("v0", 20'd0, sel(24'h000000, 24'hFFFFF0), 0, 20'd0, 1'b0);
    idle_cycles(2);
    run_conv("v1005", 20'd1005, sel(24'h001005, 24'hFF1005), 0, 20'd0, 1'b0);
    idle_cycles(2);
    run_conv("v999999", 20'd999999, 24'h999999, 0, 20'd0, 1'b0);
    idle_cycles(2);

    // Out-of-range value: saturate immediately, no conversion phase.
    Bin_Data = 20'd1000000;
    Load_Sig = 1'b1;
    @(posedge CLK); #1;
    Load_Sig = 1'b0;
    check("ovf_done_c1", Done_Sig, 1);
    check("ovf_busy_c1", Busy_Sig, 0);
    check("ovf_number", Number_Sig, 24'h999999);
    check("ovf_flag", Ovf_Sig, 1);
    @(posedge CLK); #1;
    check("ovf_done_end", Done_Sig, 0);
    check("ovf_flag_held", Ovf_Sig, 1);
    exp_num = 24'h999999;
    idle_cycles(1);

    // Ovf_Sig stays high through the conversion and clears with Done_Sig.
    run_conv("v42", 20'd42, sel(24'h000042, 24'hFFFF42), 0, 20'd0, 1'b1);
    idle_cycles(2);

    // Load during CONV ignored, then load accepted in the DONE cycle.
    run_conv("v500", 20'd500, sel(24'h000500, 24'hFFF500), 5, 20'd777, 1'b0);
    run_conv("v777", 20'd777, sel(24'h000777, 24'hFFF777), 0, 20'd0, 1'b0);
    idle_cycles(2);

    // Reset mid-conversion clears everything immediately.
    Bin_Data = 20'd654321;
    Load_Sig = 1'b1;
    @(posedge CLK); #1;
    Load_Sig = 1'b0;
    idle_cycles(9);
    check("abort_busy_before", Busy_Sig, 1);
    RST = 1'b1;
    #1;
    check("abort_number", Number_Sig, 24'h000000);
    check("abort_busy", Busy_Sig, 0);
    check("abort_done", Done_Sig, 0);
    check("abort_ovf", Ovf_Sig, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_num = 24'h000000;
    idle_cycles(15);
    check("abort_no_late_done", Done_Sig, 0);
    check("abort_number_still_zero", Number_Sig, 24'h000000);
    run_conv("v11", 20'd11, sel(24'h000011, 24'hFFFF11), 0, 20'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
